ctrl_package_responder: RTL and testbench
=========================================

// Module: ctrl_package_responder
// PURPOSE
//  Far-end peer of the control-package link. Receives 2-bit-per-cycle control frames:
//  128-bit package, MSB first, followed by a 16'hFFFF trailer, for 144 bits / 72 dibits total.
//  Validates and delivers each frame, then returns a reply frame in the same format after a fixed turnaround.
//  Sits at the remote node, between the link pins and the node's register/command logic.
// PARAMETERS
//  PKG_W       128      payload width in bits; PKG_W+PAD_W must be even
//  PAD_W       16       trailer width in bits
//  PAD_PATTERN 16'hFFFF required trailer value
//  TURNAROUND  4        idle cycles between rx_valid and first reply dibit; minimum 1
// PORTS
//  sys_clk          in   1      single system clock; all logic on rising edge
//  rst_n            in   1      asynchronous active-low reset
//  ctrl_rx_data     in   2      received dibit; bit[1] is the earlier (more significant) bit
//  ctrl_rx_dv       in   1      ctrl_rx_data valid this cycle
//  ctrl_tx_clk      out  1      forwarded clock, equal to sys_clk
//  ctrl_tx_data     out  2      reply dibit, MSB first; 2'b00 when ctrl_tx_en=0
//  ctrl_tx_en       out  1      reply dibit valid
//  reply_en         in   1      1 = answer good frames; 0 = receive only
//  reply_package_i  in   PKG_W  reply payload; sampled on the GAP->SEND edge
//  rx_package_o     out  PKG_W  last good payload; held until the next good frame
//  rx_valid         out  1      1-cycle pulse: good frame delivered
//  rx_err           out  1      1-cycle pulse: bad trailer or short frame
//  reply_busy       out  1      high in GAP and SEND
//  reply_overrun    out  1      1-cycle pulse: good frame arrived while reply_busy; that frame gets no reply
//  rx_frame_cnt_o   out  16     good-frame count; wraps FFFF->0000
// BEHAVIOUR
//  Reset values: every output 0, except ctrl_tx_clk, which follows sys_clk. FSM = IDLE; RX counter = 0.
//  RX path
//   - Each cycle with dv=1 and cnt<72: shift {sr,data} into the 144-bit register and increment cnt.
//   - On the edge where cnt reaches 72:
//     - trailer == PAD_PATTERN: rx_package_o <= sr[143:16]; rx_valid pulses the next cycle; rx_frame_cnt_o increments.
//     - otherwise: rx_err pulses; rx_package_o is unchanged.
//   - dv=1 while cnt=72: dibits ignored, no pulse. Frame ends at the first dv=0; cnt <= 0.
//   - dv falls with 0<cnt<72: rx_err pulses the cycle after dv=0; cnt <= 0. A dv=0 cycle with cnt=0 does nothing.
//   - RX runs independently of the TX FSM, so full-duplex frames are legal.
//  Reply FSM (states IDLE, GAP, SEND; gap counter and dibit counter)
//   - IDLE: on rx_valid=1 with reply_en=1 -> GAP, gap counter cleared. rx_valid with reply_en=0 -> stay in IDLE.
//   - GAP: counts TURNAROUND cycles, then -> SEND, loading {payload, PAD_PATTERN} into the TX shift register.
//   - SEND: ctrl_tx_en=1 for exactly 72 consecutive cycles; data = top dibit, shift left 2 each cycle.
//     After the 72nd dibit -> IDLE; ctrl_tx_en=0 the following cycle.
//   - Timing: rx_valid high in cycle N -> ctrl_tx_en first high in cycle N+TURNAROUND+1, last high in N+TURNAROUND+72.
//   - rx_valid during GAP/SEND: reply_overrun pulses in the same cycle as rx_valid; FSM unaffected; nothing queued.
//   - reply_en falling during GAP/SEND: the current reply completes.
//   - All link outputs are registered. Reset mid-SEND forces ctrl_tx_en=0 and data=00 immediately (async).
// CONFIGURATION
//  CTRL_RESP_ECHO_EN defined: reply payload = rx_package_o as of the GAP->SEND edge; reply_package_i is ignored (loopback responder).
//  Not defined: reply payload = reply_package_i sampled on the GAP->SEND edge.
// TESTING
//  1. Frame A5B6C7D8_E9FA0B1C_2D3E4F50_61728394+FFFF, 72 dibits, dv continuous, reply_package_i=0123...CDEF, TURNAROUND=4
//     -> rx_valid 1 pulse; rx_package_o=A5B6..8394; rx_frame_cnt_o=1; ctrl_tx_en high 72 cycles starting N+5;
//        captured TX = 0123..CDEF then FFFF.
//  2. Same frame with trailer FFFE -> rx_err 1 pulse, no rx_valid, rx_package_o unchanged, no ctrl_tx_en.
//  3. dv drops after 40 dibits -> rx_err the cycle after dv=0; a following full good frame -> rx_valid; cnt restarted.
//  4. Second good frame whose rx_valid lands mid-SEND -> reply_overrun 1 pulse;
//     the first reply stays 72 dibits intact; no second reply.
//  5. Assert rst_n=0 at SEND dibit 10 -> ctrl_tx_en=0, all outputs 0; after release, a good frame gives a normal reply.
//  6. With CTRL_RESP_ECHO_EN and frame of test 1 -> TX payload = A5B6..8394+FFFF; reply_en=0 -> rx_valid but no TX.

Source files
------------

// File: rtl/ctrl_package_responder.sv
// Far-end responder for the 2-bit control-package link: receives and validates frames,
// then returns a reply frame after a fixed turnaround. Define CTRL_RESP_ECHO_EN for loopback replies.
module ctrl_package_responder #(
    parameter int                PKG_W       = 128,
    parameter int                PAD_W       = 16,
    parameter logic [PAD_W-1:0]  PAD_PATTERN = 16'hFFFF,
    parameter int                TURNAROUND  = 4
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [1:0]       ctrl_rx_data,
    input  logic             ctrl_rx_dv,
    output logic             ctrl_tx_clk,
    output logic [1:0]       ctrl_tx_data,
    output logic             ctrl_tx_en,
    input  logic             reply_en,
    input  logic [PKG_W-1:0] reply_package_i,
    output logic [PKG_W-1:0] rx_package_o,
    output logic             rx_valid,
    output logic             rx_err,
    output logic             reply_busy,
    output logic             reply_overrun,
    output logic [15:0]      rx_frame_cnt_o
);

    localparam int TOT_W = PKG_W + PAD_W;
    localparam int NDIB  = TOT_W / 2;
    localparam int CW    = $clog2(NDIB + 1);
    localparam int GW    = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [CW-1:0] NDIB_C   = CW'(NDIB);
    localparam logic [CW-1:0] LAST_C   = CW'(NDIB - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TURNAROUND - 1);

    typedef enum logic [1:0] {IDLE, GAP, SEND} state_t;

    assign ctrl_tx_clk = sys_clk;

    // ---------------- RX path ----------------
    logic [TOT_W-1:0] rx_sr, rx_sr_nx;
    logic [CW-1:0]    rx_cnt;

    assign rx_sr_nx = {rx_sr[TOT_W-3:0], ctrl_rx_data};

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr          <= '0;
            rx_cnt         <= '0;
            rx_package_o   <= '0;
            rx_valid       <= 1'b0;
            rx_err         <= 1'b0;
            rx_frame_cnt_o <= '0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (ctrl_rx_dv) begin
                // Once a full frame is in, extra dibits are dropped until dv falls.
                if (rx_cnt != NDIB_C) begin
                    rx_sr  <= rx_sr_nx;
                    rx_cnt <= rx_cnt + CW'(1);
                    if (rx_cnt == LAST_C) begin
                        if (rx_sr_nx[PAD_W-1:0] == PAD_PATTERN) begin
                            rx_package_o   <= rx_sr_nx[TOT_W-1:PAD_W];
                            rx_valid       <= 1'b1;
                            rx_frame_cnt_o <= rx_frame_cnt_o + 16'd1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end
                end
            end else begin
                if (rx_cnt != '0 && rx_cnt != NDIB_C)
                    rx_err <= 1'b1;
                rx_cnt <= '0;
            end
        end
    end

    // ---------------- Reply FSM ----------------
    state_t           state, state_nx;
    logic [GW-1:0]    gap_cnt, gap_nx;
    logic [CW-1:0]    dib_cnt, dib_nx;
    logic [TOT_W-1:0] tx_sr, tx_sr_nx, tx_load;
    logic [1:0]       tx_data_nx;
    logic             tx_en_nx;

`ifdef CTRL_RESP_ECHO_EN
    assign tx_load = {rx_package_o, PAD_PATTERN};
`else
    assign tx_load = {reply_package_i, PAD_PATTERN};
`endif

    assign reply_busy    = (state != IDLE);
    assign reply_overrun = rx_valid && (state != IDLE);

    always_comb begin
        state_nx   = state;
        gap_nx     = gap_cnt;
        dib_nx     = dib_cnt;
        tx_sr_nx   = tx_sr;
        tx_data_nx = 2'b00;
        tx_en_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && reply_en) begin
                    state_nx = GAP;
                    gap_nx   = '0;
                end
            end
            GAP: begin
                // The first dibit is registered on this edge so it appears at N+TURNAROUND+1.
                if (gap_cnt == GAP_LAST) begin
                    state_nx   = SEND;
                    tx_en_nx   = 1'b1;
                    tx_data_nx = tx_load[TOT_W-1 -: 2];
                    tx_sr_nx   = {tx_load[TOT_W-3:0], 2'b00};
                    dib_nx     = CW'(1);
                end else begin
                    gap_nx = gap_cnt + GW'(1);
                end
            end
            SEND: begin
                if (dib_cnt == NDIB_C) begin
                    state_nx = IDLE;
                end else begin
                    tx_en_nx   = 1'b1;
                    tx_data_nx = tx_sr[TOT_W-1 -: 2];
                    tx_sr_nx   = {tx_sr[TOT_W-3:0], 2'b00};
                    dib_nx     = dib_cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            dib_cnt      <= '0;
            tx_sr        <= '0;
            ctrl_tx_data <= 2'b00;
            ctrl_tx_en   <= 1'b0;
        end else begin
            state        <= state_nx;
            gap_cnt      <= gap_nx;
            dib_cnt      <= dib_nx;
            tx_sr        <= tx_sr_nx;
            ctrl_tx_data <= tx_data_nx;
            ctrl_tx_en   <= tx_en_nx;
        end
    end

endmodule

// File: tb/tb_ctrl_package_responder.sv
// Directed bench for ctrl_package_responder: good/bad/short frames, overrun, mid-send reset,
// receive-only mode; reply payload expectation follows CTRL_RESP_ECHO_EN.
module tb_ctrl_package_responder;

    localparam int PKG_W = 128;
    localparam int TOT_W = 144;

    logic             sys_clk = 1'b0;
    logic             rst_n;
    logic [1:0]       ctrl_rx_data;
    logic             ctrl_rx_dv;
    logic             ctrl_tx_clk;
    logic [1:0]       ctrl_tx_data;
    logic             ctrl_tx_en;
    logic             reply_en;
    logic [PKG_W-1:0] reply_package_i;
    logic [PKG_W-1:0] rx_package_o;
    logic             rx_valid, rx_err, reply_busy, reply_overrun;
    logic [15:0]      rx_frame_cnt_o;

    ctrl_package_responder dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .ctrl_rx_data(ctrl_rx_data), .ctrl_rx_dv(ctrl_rx_dv),
        .ctrl_tx_clk(ctrl_tx_clk), .ctrl_tx_data(ctrl_tx_data), .ctrl_tx_en(ctrl_tx_en),
        .reply_en(reply_en), .reply_package_i(reply_package_i),
        .rx_package_o(rx_package_o), .rx_valid(rx_valid), .rx_err(rx_err),
        .reply_busy(reply_busy), .reply_overrun(reply_overrun),
        .rx_frame_cnt_o(rx_frame_cnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Link monitor, sampled mid-cycle.
    int               nvalid, nerr, novr, tx_cnt, tx_first, tx_last, valid_cyc, err_cyc, drop_cyc;
    logic [TOT_W-1:0] tx_cap;

    always @(negedge sys_clk) begin
        if (rx_valid) begin nvalid++; valid_cyc = cyc; end
        if (rx_err) begin nerr++; err_cyc = cyc; end
        if (reply_overrun) novr++;
        if (ctrl_tx_en) begin
            if (tx_cnt == 0) tx_first = cyc;
            tx_last = cyc;
            tx_cap  = {tx_cap[TOT_W-3:0], ctrl_tx_data};
            tx_cnt++;
        end
    end

    task automatic clear_mon();
        nvalid = 0; nerr = 0; novr = 0; tx_cnt = 0; tx_first = 0; tx_last = 0;
        valid_cyc = 0; err_cyc = 0; tx_cap = '0;
    endtask

    task automatic chk(input string tag, input logic [TOT_W-1:0] got, input logic [TOT_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [TOT_W-1:0] f, input int ndib);
        for (int i = 0; i < ndib; i++) begin
            @(posedge sys_clk); #1;
            ctrl_rx_dv   = 1'b1;
            ctrl_rx_data = f[TOT_W-1-2*i -: 2];
        end
        @(posedge sys_clk); #1;
        ctrl_rx_dv   = 1'b0;
        ctrl_rx_data = 2'b00;
        drop_cyc     = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // Checks a completed reply: 72 contiguous dibits carrying payload then trailer.
    task automatic chk_reply(input string tag, input logic [PKG_W-1:0] pay);
        chk({tag, "_txlen"}, TOT_W'(tx_cnt), TOT_W'(72));
        chk({tag, "_txcontig"}, TOT_W'(tx_last - tx_first + 1), TOT_W'(72));
        chk({tag, "_txdata"}, tx_cap, {pay, 16'hFFFF});
    endtask

    logic [PKG_W-1:0] f1, fb, fc, rpl, exp1;
    bit               hit;

    initial begin
        f1  = 128'hA5B6C7D8_E9FA0B1C_2D3E4F50_61728394;
        fb  = 128'h11112222_33334444_55556666_77778888;
        fc  = 128'hDEADBEEF_CAFEF00D_01020304_05060708;
        rpl = 128'h0123456789ABCDEF_0123456789ABCDEF;
        rst_n = 1'b0; ctrl_rx_dv = 1'b0; ctrl_rx_data = 2'b00;
        reply_en = 1'b1; reply_package_i = rpl;
        clear_mon();
        idle(3);
        chk("rst_tx_en", TOT_W'(ctrl_tx_en), '0);
        chk("rst_outs", TOT_W'({ctrl_tx_data, rx_valid, rx_err, reply_busy, reply_overrun, rx_frame_cnt_o}), '0);
        chk("rst_pkg", TOT_W'(rx_package_o), '0);
        rst_n = 1'b1;
        idle(2);

        // 1: good frame with reply
        clear_mon();
        send_frame({f1, 16'hFFFF}, 72);
        idle(90);
`ifdef CTRL_RESP_ECHO_EN
        exp1 = f1;
`else
        exp1 = rpl;
`endif
        chk("t1_nvalid", TOT_W'(nvalid), TOT_W'(1));
        chk("t1_pkg", TOT_W'(rx_package_o), TOT_W'(f1));
        chk("t1_fcnt", TOT_W'(rx_frame_cnt_o), TOT_W'(1));
        chk("t1_latency", TOT_W'(tx_first - valid_cyc), TOT_W'(5));
        chk_reply("t1", exp1);
        chk("t1_nerr", TOT_W'(nerr), '0);

        // 2: bad trailer
        clear_mon();
        send_frame({fb, 16'hFFFE}, 72);
        idle(20);
        chk("t2_nerr", TOT_W'(nerr), TOT_W'(1));
        chk("t2_nvalid", TOT_W'(nvalid), '0);
        chk("t2_pkg", TOT_W'(rx_package_o), TOT_W'(f1));
        chk("t2_tx", TOT_W'(tx_cnt), '0);
        chk("t2_fcnt", TOT_W'(rx_frame_cnt_o), TOT_W'(1));

        // 3: short frame then a good one
        clear_mon();
        send_frame({fb, 16'hFFFF}, 40);
        idle(3);
        chk("t3_nerr", TOT_W'(nerr), TOT_W'(1));
        chk("t3_errcyc", TOT_W'(err_cyc - drop_cyc), TOT_W'(1));
        send_frame({fb, 16'hFFFF}, 72);
        idle(90);
        chk("t3_nvalid", TOT_W'(nvalid), TOT_W'(1));
        chk("t3_pkg", TOT_W'(rx_package_o), TOT_W'(fb));
        chk("t3_fcnt", TOT_W'(rx_frame_cnt_o), TOT_W'(2));
`ifdef CTRL_RESP_ECHO_EN
        chk_reply("t3", fb);
`else
        chk_reply("t3", rpl);
`endif

        // 4: second frame lands mid-reply
        clear_mon();
        send_frame({fb, 16'hFFFF}, 72);
        send_frame({fc, 16'hFFFF}, 72);
        idle(100);
        chk("t4_nvalid", TOT_W'(nvalid), TOT_W'(2));
        chk("t4_novr", TOT_W'(novr), TOT_W'(1));
        chk("t4_pkg", TOT_W'(rx_package_o), TOT_W'(fc));
        chk("t4_fcnt", TOT_W'(rx_frame_cnt_o), TOT_W'(4));
`ifdef CTRL_RESP_ECHO_EN
        chk_reply("t4", fb);
`else
        chk_reply("t4", rpl);
`endif
        chk("t4_busy", TOT_W'(reply_busy), '0);

        // 5: reset at SEND dibit 10
        clear_mon();
        send_frame({f1, 16'hFFFF}, 72);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge sys_clk);
            if (tx_cnt == 10) hit = 1'b1;
        end
        chk("t5_reach10", TOT_W'(hit), TOT_W'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_tx_en", TOT_W'(ctrl_tx_en), '0);
        chk("t5_outs", TOT_W'({ctrl_tx_data, rx_valid, rx_err, reply_busy, reply_overrun, rx_frame_cnt_o}), '0);
        chk("t5_pkg", TOT_W'(rx_package_o), '0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        clear_mon();
        send_frame({f1, 16'hFFFF}, 72);
        idle(90);
        chk("t5_fcnt", TOT_W'(rx_frame_cnt_o), TOT_W'(1));
        chk("t5_latency", TOT_W'(tx_first - valid_cyc), TOT_W'(5));
        chk_reply("t5", exp1);

        // 6: receive-only mode
        clear_mon();
        reply_en = 1'b0;
        send_frame({fc, 16'hFFFF}, 72);
        idle(90);
        chk("t6_nvalid", TOT_W'(nvalid), TOT_W'(1));
        chk("t6_pkg", TOT_W'(rx_package_o), TOT_W'(fc));
        chk("t6_tx", TOT_W'(tx_cnt), '0);
        chk("t6_busy", TOT_W'(reply_busy), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
